// File: rtl/stream_fanout_pkg.sv
// Shared defaults and types for the stream_fanout_fork slice.
package stream_fanout_pkg;

  localparam int unsigned N_CH_DEF  = 2;
  localparam int unsigned WIDTH_DEF = 1;
  localparam int unsigned CNT_W_DEF = 16;

  typedef logic [N_CH_DEF-1:0] chan_mask_t;

endpackage : stream_fanout_pkg

// File: rtl/stream_fanout_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module stream_fanout_sat_cnt
  import stream_fanout_pkg::*;
#(
  parameter int unsigned W = CNT_W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : stream_fanout_sat_cnt

// File: rtl/stream_fanout_fork.sv
// One-entry broadcast fork: a valid/ready stream fanned out to N_CH channels.
// Optional stall counter ports/logic under STREAM_FANOUT_STALL_CNT_EN.
module stream_fanout_fork
  import stream_fanout_pkg::*;
#(
  parameter int unsigned N_CH  = N_CH_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [N_CH-1:0]       chan_en,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       out_ready,
  output logic [N_CH*WIDTH-1:0] out_data
`ifdef STREAM_FANOUT_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  input  logic                  stall_clr
`endif
);

  logic [N_CH-1:0]  pend_q, pend_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic [N_CH-1:0]  take;
  logic [N_CH-1:0]  remaining;
  logic             accept;

  // Ready also when every outstanding delivery completes this cycle,
  // so a final take and a new accept can share a cycle without a bubble.
  always_comb begin
    take      = pend_q & out_ready;
    remaining = pend_q & ~take;
    in_ready  = (remaining == '0);
    accept    = in_valid & in_ready;
    pend_d    = remaining;
    buf_d     = buf_q;
    if (accept) begin
      pend_d = chan_en;
      buf_d  = in_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
      buf_q  <= '0;
    end else begin
      pend_q <= pend_d;
      buf_q  <= buf_d;
    end
  end

  assign out_valid = pend_q;
  assign out_data  = {N_CH{buf_q}};

`ifdef STREAM_FANOUT_STALL_CNT_EN
  stream_fanout_sat_cnt #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .clr_i  (stall_clr),
    .inc_i  (in_valid & ~in_ready),
    .cnt_o  (stall_cnt)
  );
`endif

endmodule : stream_fanout_fork

// File: tb/tb_stream_fanout_fork.sv
// Directed self-checking bench for stream_fanout_fork (N_CH=2, WIDTH=8).
module tb_stream_fanout_fork;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  chan_en;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [15:0] out_data;
`ifdef STREAM_FANOUT_STALL_CNT_EN
  logic [3:0]  stall_cnt;
  logic        stall_clr;
`endif

  int checks = 0;
  int errors = 0;

  stream_fanout_fork #(
    .N_CH  (2),
    .WIDTH (8),
    .CNT_W (4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .chan_en   (chan_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef STREAM_FANOUT_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .stall_clr (stall_clr)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    chan_en   = 2'b00;
    out_ready = 2'b00;
`ifdef STREAM_FANOUT_STALL_CNT_EN
    stall_clr = 1'b0;
`endif
    #2;
    chk("rst_valid", {30'd0, out_valid}, 32'h0);
    chk("rst_data", {16'd0, out_data}, 32'h0);
    chk("rst_ready", {31'd0, in_ready}, 32'h1);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("idle_valid", {30'd0, out_valid}, 32'h0);
    chk("idle_data", {16'd0, out_data}, 32'h0);
    chk("idle_ready", {31'd0, in_ready}, 32'h1);

    // Back-to-back, all channels ready
    out_ready = 2'b11; chan_en = 2'b11; in_valid = 1'b1; in_data = 8'h11;
    #1 chk("b2b_rdy0", {31'd0, in_ready}, 32'h1);
    tick();
    chk("b2b_v1", {30'd0, out_valid}, 32'h3);
    chk("b2b_d1", {16'd0, out_data}, 32'h1111);
    in_data = 8'h22;
    #1 chk("b2b_rdy1", {31'd0, in_ready}, 32'h1);
    tick();
    chk("b2b_d2", {16'd0, out_data}, 32'h2222);
    in_data = 8'h33;
    #1 chk("b2b_rdy2", {31'd0, in_ready}, 32'h1);
    tick();
    chk("b2b_v3", {30'd0, out_valid}, 32'h3);
    chk("b2b_d3", {16'd0, out_data}, 32'h3333);
    in_valid = 1'b0;
    tick();
    chk("b2b_drain", {30'd0, out_valid}, 32'h0);

    // Skewed readiness: ch1 stalls three cycles
    out_ready = 2'b01; in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_data = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      #1 chk("skew_rdy", {31'd0, in_ready}, 32'h0);
      tick();
      chk("skew_v", {30'd0, out_valid}, 32'h2);
      chk("skew_d", {16'd0, out_data}, 32'hA5A5);
    end
    out_ready = 2'b11;
    #1 chk("skew_rdy_take", {31'd0, in_ready}, 32'h1);
    tick();
    chk("skew_next_v", {30'd0, out_valid}, 32'h3);
    chk("skew_next_d", {16'd0, out_data}, 32'h3C3C);
    in_valid = 1'b0;
    tick();
    chk("skew_drain", {30'd0, out_valid}, 32'h0);

    // Masking
    out_ready = 2'b00; chan_en = 2'b10; in_valid = 1'b1; in_data = 8'h5A;
    #1 chk("mask_rdy", {31'd0, in_ready}, 32'h1);
    tick();
    in_valid = 1'b0;
    chk("mask_v", {30'd0, out_valid}, 32'h2);
    chk("mask_d", {16'd0, out_data}, 32'h5A5A);
    out_ready = 2'b11;
    tick();
    chk("mask_drain", {30'd0, out_valid}, 32'h0);
    chan_en = 2'b00; in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    chk("mask0_v", {30'd0, out_valid}, 32'h0);
    chk("mask0_d", {16'd0, out_data}, 32'h7777);
    #1 chk("mask0_rdy", {31'd0, in_ready}, 32'h1);

    // Reset mid-beat
    out_ready = 2'b00; chan_en = 2'b10; in_valid = 1'b1; in_data = 8'h99;
    tick();
    in_valid = 1'b0;
    chk("mid_v", {30'd0, out_valid}, 32'h2);
    #2 reset_n = 1'b0;
    #1 chk("mid_rst_v", {30'd0, out_valid}, 32'h0);
    chk("mid_rst_d", {16'd0, out_data}, 32'h0);
    chk("mid_rst_rdy", {31'd0, in_ready}, 32'h1);
    tick();
    #2 reset_n = 1'b1;
    out_ready = 2'b11;
    tick();
    tick();
    chk("mid_after_v", {30'd0, out_valid}, 32'h0);

`ifdef STREAM_FANOUT_STALL_CNT_EN
    chk("stall_rst", {28'd0, stall_cnt}, 32'h0);
    out_ready = 2'b00; chan_en = 2'b10; in_valid = 1'b1; in_data = 8'h42;
    tick();
    chk("stall_first", {28'd0, stall_cnt}, 32'h0);
    for (int i = 0; i < 20; i++) tick();
    chk("stall_sat", {28'd0, stall_cnt}, 32'hF);
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    chk("stall_clr", {28'd0, stall_cnt}, 32'h0);
    tick();
    chk("stall_resume", {28'd0, stall_cnt}, 32'h1);
    in_valid = 1'b0; out_ready = 2'b11;
    tick();
    chk("stall_hold", {28'd0, stall_cnt}, 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_stream_fanout_fork
